// File: rtl/burst_arbiter.sv
// burst_arbiter
//   Shares one burst-memory port (bmem_*) between the instruction-side and
//   data-side cacheline adapters. A grant always covers a whole burst of BEATS
//   beats. When both sides request in the same cycle, the side that did not
//   have the previous grant wins (round-robin).
//
// Parameters
//   BEATS   beats per burst (>= 2)
//   DATA_W  beat width
//   ADDR_W  address width
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   i_bmem_{address,read,write,wdata} / i_bmem_{rdata,resp}   I-side requester
//   d_bmem_{address,read,write,wdata} / d_bmem_{rdata,resp}   D-side requester
//   bmem_{address,read,write,wdata} / bmem_{rdata,resp}       burst memory
//
// Optional build macro BURST_ARB_STATS_EN adds three 32-bit saturating
// counters: i_burst_count, d_burst_count, wait_cycles.
module burst_arbiter #(
  parameter int BEATS  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_bmem_address,
  input  logic              i_bmem_read,
  input  logic              i_bmem_write,
  input  logic [DATA_W-1:0] i_bmem_wdata,
  output logic [DATA_W-1:0] i_bmem_rdata,
  output logic              i_bmem_resp,
  input  logic [ADDR_W-1:0] d_bmem_address,
  input  logic              d_bmem_read,
  input  logic              d_bmem_write,
  input  logic [DATA_W-1:0] d_bmem_wdata,
  output logic [DATA_W-1:0] d_bmem_rdata,
  output logic              d_bmem_resp,
  output logic [ADDR_W-1:0] bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [DATA_W-1:0] bmem_wdata,
  input  logic [DATA_W-1:0] bmem_rdata,
  input  logic              bmem_resp
`ifdef BURST_ARB_STATS_EN
  ,
  output logic [31:0]       i_burst_count,
  output logic [31:0]       d_burst_count,
  output logic [31:0]       wait_cycles
`endif
);

  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_last_d;     // 1: last grant went to D, 0: to I

  logic w_i_req, w_d_req, w_pick_i, w_pick_d, w_last_beat;

  assign w_i_req = i_bmem_read | i_bmem_write;
  assign w_d_req = d_bmem_read | d_bmem_write;
  // With both requesting, D wins unless D had the previous grant.
  assign w_pick_d    = w_d_req & (~w_i_req | ~r_last_d);
  assign w_pick_i    = w_i_req & ~w_pick_d;
  assign w_last_beat = bmem_resp & (r_beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_last_d   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // responses arriving with no grant are dropped, counter untouched
          if (w_pick_d) begin
            r_state  <= GRANT_D;
            r_last_d <= 1'b1;
          end else if (w_pick_i) begin
            r_state  <= GRANT_I;
            r_last_d <= 1'b0;
          end
        end
        GRANT_I, GRANT_D: begin
          // grant is held until BEATS responses, even if the requester drops
          if (w_last_beat) begin
            r_beat_cnt <= '0;
            r_state    <= IDLE;
          end else if (bmem_resp) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  // Request side is forwarded combinationally from the owner; nothing latched.
  always_comb begin
    bmem_address = '0;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_wdata   = '0;
    i_bmem_resp  = 1'b0;
    d_bmem_resp  = 1'b0;
    i_bmem_rdata = '0;
    d_bmem_rdata = '0;
    case (r_state)
      GRANT_I: begin
        bmem_address = i_bmem_address;
        bmem_read    = i_bmem_read;
        bmem_write   = i_bmem_write;
        bmem_wdata   = i_bmem_wdata;
        i_bmem_resp  = bmem_resp;
        i_bmem_rdata = bmem_rdata;
        d_bmem_rdata = bmem_rdata;
      end
      GRANT_D: begin
        bmem_address = d_bmem_address;
        bmem_read    = d_bmem_read;
        bmem_write   = d_bmem_write;
        bmem_wdata   = d_bmem_wdata;
        d_bmem_resp  = bmem_resp;
        i_bmem_rdata = bmem_rdata;
        d_bmem_rdata = bmem_rdata;
      end
      default: ;
    endcase
  end

`ifdef BURST_ARB_STATS_EN
  logic [31:0] r_i_bursts, r_d_bursts, r_wait;
  logic        w_i_wait, w_d_wait;
  logic [32:0] w_wait_sum;

  // In IDLE the side being picked this cycle counts as granted, not waiting.
  assign w_i_wait   = w_i_req & ~((r_state == GRANT_I) | ((r_state == IDLE) & w_pick_i));
  assign w_d_wait   = w_d_req & ~((r_state == GRANT_D) | ((r_state == IDLE) & w_pick_d));
  assign w_wait_sum = {1'b0, r_wait} + 33'(w_i_wait) + 33'(w_d_wait);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i_bursts <= '0;
      r_d_bursts <= '0;
      r_wait     <= '0;
    end else begin
      if ((r_state == GRANT_I) && w_last_beat && (r_i_bursts != '1))
        r_i_bursts <= r_i_bursts + 32'd1;
      if ((r_state == GRANT_D) && w_last_beat && (r_d_bursts != '1))
        r_d_bursts <= r_d_bursts + 32'd1;
      r_wait <= w_wait_sum[32] ? '1 : w_wait_sum[31:0];
    end
  end

  assign i_burst_count = r_i_bursts;
  assign d_burst_count = r_d_bursts;
  assign wait_cycles   = r_wait;
`endif

endmodule

// File: tb/tb_burst_arbiter.sv
// tb_burst_arbiter
//   Directed scenarios followed by a randomized phase. Expected outputs come
//   from a transaction-level model: an "owner" (none / I / D) that holds for
//   BEATS responses, picked by round-robin when both sides want the port.
module tb_burst_arbiter;
  localparam int BEATS  = 4;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ADDR_W-1:0] i_bmem_address, d_bmem_address, bmem_address;
  logic              i_bmem_read, i_bmem_write, d_bmem_read, d_bmem_write;
  logic [DATA_W-1:0] i_bmem_wdata, d_bmem_wdata, bmem_wdata, bmem_rdata;
  logic [DATA_W-1:0] i_bmem_rdata, d_bmem_rdata;
  logic              i_bmem_resp, d_bmem_resp, bmem_read, bmem_write, bmem_resp;
`ifdef BURST_ARB_STATS_EN
  logic [31:0] i_burst_count, d_burst_count, wait_cycles;
`endif

  burst_arbiter #(.BEATS(BEATS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_bmem_address(i_bmem_address), .i_bmem_read(i_bmem_read), .i_bmem_write(i_bmem_write),
    .i_bmem_wdata(i_bmem_wdata), .i_bmem_rdata(i_bmem_rdata), .i_bmem_resp(i_bmem_resp),
    .d_bmem_address(d_bmem_address), .d_bmem_read(d_bmem_read), .d_bmem_write(d_bmem_write),
    .d_bmem_wdata(d_bmem_wdata), .d_bmem_rdata(d_bmem_rdata), .d_bmem_resp(d_bmem_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
`ifdef BURST_ARB_STATS_EN
    , .i_burst_count(i_burst_count), .d_burst_count(d_burst_count), .wait_cycles(wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // ---- reference model: owner 0=none 1=I 2=D ----
  int m_own, m_last, m_left;
  longint m_icnt, m_dcnt, m_wait;
  logic c_iresp, c_dresp;

  task automatic model_reset();
    m_own = 0; m_last = 1; m_left = 0;
    m_icnt = 0; m_dcnt = 0; m_wait = 0;
  endtask

  function automatic int pick(logic ri, logic rd);
    if (ri && rd) return (m_last == 1) ? 2 : 1;
    if (rd) return 2;
    if (ri) return 1;
    return 0;
  endfunction

  function automatic logic [255:0] expv();
    logic [ADDR_W-1:0] a = '0;
    logic rd = 1'b0, wr = 1'b0, ir = 1'b0, dr = 1'b0;
    logic [DATA_W-1:0] wd = '0, rdat = '0;
    if (m_own == 1) begin
      a = i_bmem_address; rd = i_bmem_read; wr = i_bmem_write; wd = i_bmem_wdata;
      ir = bmem_resp; rdat = bmem_rdata;
    end else if (m_own == 2) begin
      a = d_bmem_address; rd = d_bmem_read; wr = d_bmem_write; wd = d_bmem_wdata;
      dr = bmem_resp; rdat = bmem_rdata;
    end
    return 256'({a, rd, wr, wd, ir, dr, rdat, rdat});
  endfunction

  function automatic logic [255:0] obsv();
    return 256'({bmem_address, bmem_read, bmem_write, bmem_wdata,
                 i_bmem_resp, d_bmem_resp, i_bmem_rdata, d_bmem_rdata});
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    logic ri, rd, rs;
    int p;
    @(negedge clk);
    chk("outputs", obsv(), expv());
    assert (!(i_bmem_read && i_bmem_write) && !(d_bmem_read && d_bmem_write)) else begin
      n_err++;
      $error("FAIL illegal_rw: read and write both high on a requester");
    end
    ri = i_bmem_read | i_bmem_write;
    rd = d_bmem_read | d_bmem_write;
    rs = bmem_resp;
    c_iresp = i_bmem_resp;
    c_dresp = d_bmem_resp;
    p = pick(ri, rd);
    if (reset_n) begin
      if (ri && !(m_own == 1 || (m_own == 0 && p == 1))) m_wait++;
      if (rd && !(m_own == 2 || (m_own == 0 && p == 2))) m_wait++;
    end
    @(posedge clk);
    if (reset_n) begin
      if (m_own == 0) begin
        if (p != 0) begin m_own = p; m_last = p; m_left = BEATS; end
      end else if (rs) begin
        m_left--;
        if (m_left == 0) begin
          if (m_own == 1) m_icnt++; else m_dcnt++;
          m_own = 0;
        end
      end
    end
    #1;
  endtask

  // Deliver n beats to the owner 'side', updating write data per beat.
  task automatic serve(input int side, input int n, input logic [DATA_W-1:0] rbase,
                       input logic [DATA_W-1:0] wbase);
    for (int k = 0; k < n; k++) begin
      bmem_resp = 1'b1;
      bmem_rdata = rbase + DATA_W'(k);
      if (side == 1) i_bmem_wdata = wbase + DATA_W'(k);
      else           d_bmem_wdata = wbase + DATA_W'(k);
      #1;
      if (side == 1) begin
        chk($sformatf("i_resp_b%0d", k), i_bmem_resp, 1);
        chk($sformatf("i_rdata_b%0d", k), i_bmem_rdata, rbase + DATA_W'(k));
        chk($sformatf("d_quiet_b%0d", k), d_bmem_resp, 0);
      end else begin
        chk($sformatf("d_resp_b%0d", k), d_bmem_resp, 1);
        chk($sformatf("d_rdata_b%0d", k), d_bmem_rdata, rbase + DATA_W'(k));
        chk($sformatf("i_quiet_b%0d", k), i_bmem_resp, 0);
        if (d_bmem_write) begin
          chk($sformatf("d_wdata_b%0d", k), bmem_wdata, wbase + DATA_W'(k));
          chk($sformatf("d_wr_b%0d", k), {bmem_read, bmem_write}, 2'b01);
        end
      end
      step();
    end
    bmem_resp = 1'b0;
  endtask

  task automatic idle_inputs();
    i_bmem_address = '0; i_bmem_read = 1'b0; i_bmem_write = 1'b0; i_bmem_wdata = '0;
    d_bmem_address = '0; d_bmem_read = 1'b0; d_bmem_write = 1'b0; d_bmem_wdata = '0;
    bmem_resp = 1'b0; bmem_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_zero", obsv(), 256'd0);
    model_reset();
    repeat (2) step();
    idle_inputs();
    reset_n = 1'b1;
  endtask

  // Random requester: holds address/op until BEATS responses, may drop mid-burst.
  task automatic req_upd(input logic resp, inout int busy, inout int nb, inout logic drop,
                         inout logic op, inout logic [ADDR_W-1:0] a,
                         inout logic [DATA_W-1:0] wd, output logic rd, output logic wr);
    if (busy != 0 && resp) begin
      nb++;
      if (nb == BEATS) busy = 0;
      else wd = {$urandom, $urandom};
    end else if (busy != 0 && nb > 0 && !drop && $urandom_range(0, 19) == 0) begin
      drop = 1'b1;
    end
    if (busy == 0 && $urandom_range(0, 2) == 0) begin
      busy = 1; nb = 0; drop = 1'b0;
      op = ($urandom_range(0, 3) == 0);
      a = $urandom; wd = {$urandom, $urandom};
    end
    rd = (busy != 0) && !drop && !op;
    wr = (busy != 0) && !drop && op;
  endtask

  initial begin
    int w;
    int ib, ibn, db, dbn;
    logic idr, iop, ddr, dop;
    model_reset();
    idle_inputs();
    // reset with active inputs: outputs must stay 0
    i_bmem_read = 1'b1; d_bmem_write = 1'b1; bmem_resp = 1'b1; bmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    do_reset();

    // I-side read 0x40; a stray response during the IDLE cycle is ignored
    i_bmem_address = 32'h40; i_bmem_read = 1'b1; bmem_resp = 1'b1;
    #1;
    chk("i_idle_rd", bmem_read, 0);
    chk("i_idle_resp", i_bmem_resp, 0);
    step();
    bmem_resp = 1'b0;
    chk("i_grant_rd", bmem_read, 1);
    chk("i_grant_addr", bmem_address, 32'h40);
    serve(1, BEATS, 64'hA0A0_0000_0000_0000, '0);
    chk("i_back_idle", bmem_read, 0);
    i_bmem_read = 1'b0;
    step();

    // D-side write 0x1000
    d_bmem_address = 32'h1000; d_bmem_write = 1'b1; d_bmem_wdata = 64'hC0DE_0000_0000_0000;
    step();
    chk("d_grant_addr", bmem_address, 32'h1000);
    serve(2, BEATS, 64'h5555_0000_0000_0000, 64'hC0DE_0000_0000_0000);
    chk("d_back_idle", {bmem_read, bmem_write}, 2'b00);
    d_bmem_write = 1'b0;
    step();

    // simultaneous requests after reset: D first
    do_reset();
    i_bmem_address = 32'h80; i_bmem_read = 1'b1;
    d_bmem_address = 32'h2000; d_bmem_read = 1'b1;
    step();
    chk("sim_first", bmem_address, 32'h2000);
    serve(2, BEATS, 64'h1111_0000_0000_0000, '0);
    chk("sim_bubble", bmem_read, 0);
    d_bmem_read = 1'b0;
    step();
    chk("sim_second", bmem_address, 32'h80);
    serve(1, BEATS, 64'h2222_0000_0000_0000, '0);
    chk("sim_done", bmem_read, 0);
    i_bmem_read = 1'b0;
`ifdef BURST_ARB_STATS_EN
    chk("st_d", d_burst_count, 1);
    chk("st_i", i_burst_count, 1);
    chk("st_wait", wait_cycles, 1 + BEATS);
`endif
    step();

    // back-to-back contention: D,I,D,I (last grant was I)
    i_bmem_address = 32'h100; i_bmem_read = 1'b1;
    d_bmem_address = 32'h3000; d_bmem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      w = (bmem_address == 32'h3000) ? 2 : 1;
      chk($sformatf("rr_%0d", k), w, (k % 2 == 0) ? 2 : 1);
      serve(w, BEATS, 64'(k) << 32, '0);
    end
    i_bmem_read = 1'b0; d_bmem_read = 1'b0;
    step();

    // reset in the middle of a D read
    d_bmem_address = 32'h4000; d_bmem_read = 1'b1;
    step();
    serve(2, 2, 64'h3333_0000_0000_0000, '0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", obsv(), 256'd0);
    model_reset();
    step();
    reset_n = 1'b1;
    d_bmem_read = 1'b0;
    i_bmem_address = 32'h40; i_bmem_read = 1'b1;
    step();
    chk("post_rst_addr", bmem_address, 32'h40);
    serve(1, BEATS, 64'h4444_0000_0000_0000, '0);
    chk("post_rst_idle", bmem_read, 0);
    i_bmem_read = 1'b0;
    step();

    // randomized traffic against the model
    ib = 0; ibn = 0; idr = 1'b0; iop = 1'b0;
    db = 0; dbn = 0; ddr = 1'b0; dop = 1'b0;
    c_iresp = 1'b0; c_dresp = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req_upd(c_iresp, ib, ibn, idr, iop, i_bmem_address, i_bmem_wdata, i_bmem_read, i_bmem_write);
      req_upd(c_dresp, db, dbn, ddr, dop, d_bmem_address, d_bmem_wdata, d_bmem_read, d_bmem_write);
      bmem_resp = ($urandom_range(0, 9) < 6);
      bmem_rdata = {$urandom, $urandom};
      step();
    end
`ifdef BURST_ARB_STATS_EN
    chk("rand_st_i", i_burst_count, 32'(m_icnt));
    chk("rand_st_d", d_burst_count, 32'(m_dcnt));
    chk("rand_st_wait", wait_cycles, 32'(m_wait));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
